instr_encoder_loader: RTL and testbench
=======================================

Name: instr_encoder_loader

Overview:
- Opposite end of the instruction_decoder interface: takes instruction fields (opcode, format, register selects, immediate) and packs them into the 16-bit word format the decoder unpacks.
- Buffers encoded words in a small FIFO and streams them into instruction memory through a write port, one word per cycle, with an auto-incrementing address.
- Used by the test and boot infrastructure to load programs into the reduced-ARM core.

Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥2)
- ADDR_W, 8, instruction memory address width

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse; begins a load session at address 0
- in_valid  input  1  field bundle valid
- in_ready  output  1  encoder can accept a bundle
- in_last  input  1  bundle is the final instruction of the program
- in_fmt  input  2  format: 0=R, 1=I5, 2=I8, 3=I11
- in_op  input  5  opcode
- in_wsel  input  3  destination register select
- in_asel  input  3  operand A select
- in_bsel  input  3  operand B select
- in_imm  input  11  immediate; low bits used per format
- imem_we  output  1  instruction memory write strobe
- imem_addr  output  ADDR_W  write address
- imem_wdata  output  16  encoded instruction
- busy  output  1  state is LOAD or DRAIN
- load_done  output  1  high while in DONE
- wrap_err  output  1  sticky; address wrapped past 2^ADDR_W-1

Behaviour:
- Encoding, applied at push time:
  - instr[15:11] = op in every format.
  - R: [10:8]=wsel, [7:5]=asel, [4:2]=bsel, [1:0]=0.
  - I5: [10:8]=wsel, [7:5]=asel, [4:0]=imm[4:0].
  - I8: [10:8]=wsel, [7:0]=imm[7:0].
  - I11: [10:0]=imm[10:0].
  - Fields not used by the selected format are ignored.
- FSM states and transitions:
  - IDLE: start → LOAD; the address counter clears to 0, wrap_err clears, and the FIFO is flushed.
  - LOAD: an accepted bundle with in_last=1 → DRAIN.
  - DRAIN: FIFO empty and no write pending → DONE.
  - DONE: start → LOAD, with the same clearing actions as IDLE.
  - start in LOAD or DRAIN is ignored.
- Handshake:
  - in_ready = (state==LOAD) && (count<DEPTH).
  - A transfer occurs when in_valid && in_ready.
  - in_valid may be asserted at any time; fields must stay stable until the transfer.
- Drain:
  - On each edge where the FIFO is non-empty in LOAD or DRAIN, pop one entry.
  - The popped word is registered onto imem_wdata, imem_addr takes the current counter value, and imem_we is high for the following cycle.
  - The counter increments after each write.
- Latency: a bundle accepted at edge k is written with imem_we high in the cycle after edge k+1 (2 cycles) when the FIFO was empty.
- Simultaneous push and pop is legal; count is unchanged. Push at full is impossible because in_ready is low.
- Throughput: one instruction per cycle sustained.
- Wrap-around: a write at address 2^ADDR_W-1 wraps the counter to 0 and sets wrap_err. wrap_err holds until the next start or reset.
- load_done asserts in the cycle after the last write's imem_we cycle.
- Reset, at any time including mid-load:
  - state=IDLE, FIFO empty, counter=0.
  - imem_we=0, imem_addr=0, imem_wdata=0.
  - in_ready=0, busy=0, load_done=0, wrap_err=0.
  - In-flight words are discarded.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- When defined: adds output port checksum[15:0], the running XOR of every imem_wdata written in the session. It clears on start and reset, and is valid when load_done=1.
- When undefined: the port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package isa_pkg holds:
  - Format codes FMT_R, FMT_I5, FMT_I8, FMT_I11.
  - Field bit-position constants: OP_MSB/LSB, WSEL, ASEL, BSEL, IMM5, IMM8, IMM11 positions.
  - The instruction width constant 16.
  - The decoder is to adopt the same package.
- One sub-module: instr_fifo, a synchronous FIFO with DEPTH×16 entries, count, and push/pop ports.
- Encoding and FSM live in the top level.

Test Plan:
- Reset, then start, then one R bundle op=3, w=1, a=2, b=3 with last=1 → single write imem_addr=0x00, imem_wdata=0x194C; load_done high 1 cycle after the imem_we cycle.
- Stream I5 (op=4, w=7, a=0, imm=0x1F), I8 (op=10, w=5, imm=0xA5), I11 (op=31, imm=0x7FF) back-to-back with valid held high → writes 0x271F, 0x55A5, 0xFFFF at addresses 0, 1, 2 on consecutive cycles; unused fields randomised with no effect.
- Backpressure: in_valid held high and imem draining throttled by filling the FIFO in LOAD → in_ready drops at count=4, no bundle lost or duplicated, and write order is preserved.
- ADDR_W=2, load 6 words → addresses 0,1,2,3,0,1; wrap_err set on the write at address 3 and held; cleared by the next start.
- Assert rst mid-DRAIN with 2 words queued → all outputs 0 immediately (asynchronous), no further imem_we; after start, the new session begins at address 0.
- With LOADER_CHECKSUM_EN: the scenario 2 stream → checksum = 0x271F^0x55A5^0xFFFF = 0x8D45 when load_done=1.

Source files
------------

// File: rtl/isa_pkg.sv
// rtl/isa_pkg.sv - shared reduced-ARM instruction format constants for encoder and decoder
package isa_pkg;

  localparam int INSTR_W = 16;

  typedef enum logic [1:0] {
    FMT_R   = 2'd0,
    FMT_I5  = 2'd1,
    FMT_I8  = 2'd2,
    FMT_I11 = 2'd3
  } fmt_e;

  localparam int OP_MSB    = 15;
  localparam int OP_LSB    = 11;
  localparam int WSEL_MSB  = 10;
  localparam int WSEL_LSB  = 8;
  localparam int ASEL_MSB  = 7;
  localparam int ASEL_LSB  = 5;
  localparam int BSEL_MSB  = 4;
  localparam int BSEL_LSB  = 2;
  localparam int IMM5_MSB  = 4;
  localparam int IMM8_MSB  = 7;
  localparam int IMM11_MSB = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } ld_state_e;

endpackage

// File: rtl/instr_fifo.sv
// rtl/instr_fifo.sv - synchronous DEPTH x W word FIFO with occupancy count and flush
module instr_fifo
  import isa_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = INSTR_W,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          pop_i,
  output logic [W-1:0]  rdata_o,
  output logic [AW:0]   count_o,
  output logic          empty_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && (count_q != (AW+1)'(DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - packs instruction fields and streams them into imem; LOADER_CHECKSUM_EN adds checksum
module instr_encoder_loader
  import isa_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_last,
  input  logic [1:0]         in_fmt,
  input  logic [4:0]         in_op,
  input  logic [2:0]         in_wsel,
  input  logic [2:0]         in_asel,
  input  logic [2:0]         in_bsel,
  input  logic [10:0]        in_imm,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               busy,
  output logic               load_done,
`ifdef LOADER_CHECKSUM_EN
  output logic [INSTR_W-1:0] checksum,
`endif
  output logic               wrap_err
);

  localparam int AW = $clog2(DEPTH);

  ld_state_e           state_q, state_d;
  logic [INSTR_W-1:0]  enc_word;
  logic [INSTR_W-1:0]  fifo_rdata;
  logic [AW:0]         fifo_count;
  logic                fifo_empty;
  logic                push;
  logic                pop;
  logic                clear;
  logic                imem_we_q;
  logic [ADDR_W-1:0]   imem_addr_q;
  logic [INSTR_W-1:0]  imem_wdata_q;
  logic [ADDR_W-1:0]   cnt_q;
  logic                wrap_q;

  always_comb begin
    enc_word = '0;
    enc_word[OP_MSB:OP_LSB] = in_op;
    case (fmt_e'(in_fmt))
      FMT_R: begin
        enc_word[WSEL_MSB:WSEL_LSB] = in_wsel;
        enc_word[ASEL_MSB:ASEL_LSB] = in_asel;
        enc_word[BSEL_MSB:BSEL_LSB] = in_bsel;
      end
      FMT_I5: begin
        enc_word[WSEL_MSB:WSEL_LSB] = in_wsel;
        enc_word[ASEL_MSB:ASEL_LSB] = in_asel;
        enc_word[IMM5_MSB:0]        = in_imm[IMM5_MSB:0];
      end
      FMT_I8: begin
        enc_word[WSEL_MSB:WSEL_LSB] = in_wsel;
        enc_word[IMM8_MSB:0]        = in_imm[IMM8_MSB:0];
      end
      default: enc_word[IMM11_MSB:0] = in_imm[IMM11_MSB:0];
    endcase
  end

  assign in_ready  = (state_q == ST_LOAD) && (fifo_count < (AW+1)'(DEPTH));
  assign push      = in_valid && in_ready;
  assign pop       = !fifo_empty && ((state_q == ST_LOAD) || (state_q == ST_DRAIN));
  assign busy      = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
  assign load_done = (state_q == ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Leaving DRAIN on an empty FIFO lines DONE up with the edge that retires the final write.
  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_LOAD;
          clear   = 1'b1;
        end
      end
      ST_LOAD:  if (push && in_last) state_d = ST_DRAIN;
      ST_DRAIN: if (fifo_empty) state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  instr_fifo #(
    .DEPTH (DEPTH),
    .W     (INSTR_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (clear),
    .push_i  (push),
    .wdata_i (enc_word),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cnt_q        <= '0;
      wrap_q       <= 1'b0;
    end else begin
      imem_we_q <= pop;
      if (clear) begin
        cnt_q  <= '0;
        wrap_q <= 1'b0;
      end else if (pop) begin
        imem_addr_q  <= cnt_q;
        imem_wdata_q <= fifo_rdata;
        cnt_q        <= cnt_q + ADDR_W'(1);
        if (&cnt_q) wrap_q <= 1'b1;
      end
    end
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign wrap_err   = wrap_q;

`ifdef LOADER_CHECKSUM_EN
  logic [INSTR_W-1:0] csum_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        csum_q <= '0;
    else if (clear) csum_q <= '0;
    else if (pop)   csum_q <= csum_q ^ fifo_rdata;
  end

  assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb/tb_instr_encoder_loader.sv - self-checking bench for instr_encoder_loader at ADDR_W 8 and 2
module tb_instr_encoder_loader;

  typedef struct packed {
    logic [1:0]  fmt;
    logic [4:0]  op;
    logic [2:0]  w;
    logic [2:0]  a;
    logic [2:0]  b;
    logic [10:0] imm;
  } bnd_t;

  typedef struct packed {
    bnd_t        bd;
    logic [15:0] word;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_last;
  logic [1:0]  in_fmt;
  logic [4:0]  in_op;
  logic [2:0]  in_wsel, in_asel, in_bsel;
  logic [10:0] in_imm;

  logic        a_ready, a_we, a_busy, a_done, a_wrap;
  logic [7:0]  a_addr;
  logic [15:0] a_wdata;
  logic        b_ready, b_we, b_busy, b_done, b_wrap;
  logic [1:0]  b_addr;
  logic [15:0] b_wdata;
`ifdef LOADER_CHECKSUM_EN
  logic [15:0] a_csum, b_csum;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cyc = -1;
  int last_we_cyc = -1;
  int a_addr_q[$], a_data_q[$], a_cyc_q[$];
  int b_addr_q[$], b_data_q[$], b_wrap_q[$];
  int exp_q[$];
  vec_t tbl[9];

  always #5 clk = ~clk;

  instr_encoder_loader #(.DEPTH(4), .ADDR_W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(a_ready),
    .in_last(in_last), .in_fmt(in_fmt), .in_op(in_op), .in_wsel(in_wsel),
    .in_asel(in_asel), .in_bsel(in_bsel), .in_imm(in_imm), .imem_we(a_we),
    .imem_addr(a_addr), .imem_wdata(a_wdata), .busy(a_busy), .load_done(a_done),
`ifdef LOADER_CHECKSUM_EN
    .checksum(a_csum),
`endif
    .wrap_err(a_wrap)
  );

  instr_encoder_loader #(.DEPTH(4), .ADDR_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(b_ready),
    .in_last(in_last), .in_fmt(in_fmt), .in_op(in_op), .in_wsel(in_wsel),
    .in_asel(in_asel), .in_bsel(in_bsel), .in_imm(in_imm), .imem_we(b_we),
    .imem_addr(b_addr), .imem_wdata(b_wdata), .busy(b_busy), .load_done(b_done),
`ifdef LOADER_CHECKSUM_EN
    .checksum(b_csum),
`endif
    .wrap_err(b_wrap)
  );

  always @(negedge clk) begin
    cyc++;
    if (a_we === 1'b1) begin
      a_addr_q.push_back(int'(a_addr));
      a_data_q.push_back(int'(a_wdata));
      a_cyc_q.push_back(cyc);
      last_we_cyc = cyc;
    end
    if (b_we === 1'b1) begin
      b_addr_q.push_back(int'(b_addr));
      b_data_q.push_back(int'(b_wdata));
      b_wrap_q.push_back(int'(b_wrap));
    end
    if (a_done === 1'b1 && done_cyc < 0) done_cyc = cyc;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bnd_t mk(input int fmt, input int op, input int w, input int a,
                              input int b, input int imm);
    bnd_t r;
    r.fmt = 2'(fmt); r.op = 5'(op); r.w = 3'(w); r.a = 3'(a); r.b = 3'(b); r.imm = 11'(imm);
    return r;
  endfunction

  function automatic bnd_t rand_bnd();
    return mk($urandom_range(0, 3), $urandom_range(0, 31), $urandom_range(0, 7),
              $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 2047));
  endfunction

  // Reference encoding from field weights rather than bit slicing.
  function automatic logic [15:0] model_enc(input bnd_t bd);
    int v;
    v = int'(bd.op) * 2048;
    case (bd.fmt)
      2'd0:    v += int'(bd.w) * 256 + int'(bd.a) * 32 + int'(bd.b) * 4;
      2'd1:    v += int'(bd.w) * 256 + int'(bd.a) * 32 + int'(bd.imm) % 32;
      2'd2:    v += int'(bd.w) * 256 + int'(bd.imm) % 256;
      default: v += int'(bd.imm);
    endcase
    return v[15:0];
  endfunction

  task automatic drive(input bnd_t bd);
    in_fmt = bd.fmt; in_op = bd.op; in_wsel = bd.w;
    in_asel = bd.a; in_bsel = bd.b; in_imm = bd.imm;
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    drive(rand_bnd());
    @(posedge clk); #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a_addr_q.delete(); a_data_q.delete(); a_cyc_q.delete();
    b_addr_q.delete(); b_data_q.delete(); b_wrap_q.delete();
    exp_q.delete();
    done_cyc = -1;
    last_we_cyc = -1;
  endtask

  task automatic send(input bnd_t bd, input bit last);
    int g = 0;
    in_valid = 1'b1;
    in_last = last;
    drive(bd);
    @(negedge clk);
    while (a_ready !== 1'b1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (a_ready !== 1'b1) begin
      chk("ready_timeout", 32'(a_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(int'(model_enc(bd)));
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_done();
    int g = 0;
    while (a_done !== 1'b1 && g < 200) begin
      @(negedge clk);
      g++;
    end
    #1;
    chk("load_done_seen", 32'(a_done), 32'd1);
  endtask

  task automatic check_session(input string tag);
    int n, m8, m2, x;
    n = exp_q.size();
    chk({tag, "_nwrites8"}, a_data_q.size(), n);
    chk({tag, "_nwrites2"}, b_data_q.size(), n);
    m8 = (a_data_q.size() < n) ? a_data_q.size() : n;
    m2 = (b_data_q.size() < n) ? b_data_q.size() : n;
    for (int i = 0; i < m8; i++) begin
      chk($sformatf("%s_data8[%0d]", tag, i), a_data_q[i], exp_q[i]);
      chk($sformatf("%s_addr8[%0d]", tag, i), a_addr_q[i], i % 256);
    end
    for (int i = 0; i < m2; i++) begin
      chk($sformatf("%s_data2[%0d]", tag, i), b_data_q[i], exp_q[i]);
      chk($sformatf("%s_addr2[%0d]", tag, i), b_addr_q[i], i % 4);
      chk($sformatf("%s_wrap2[%0d]", tag, i), b_wrap_q[i], (i >= 3) ? 1 : 0);
    end
    chk({tag, "_done_timing"}, done_cyc, last_we_cyc + 1);
    chk({tag, "_wrap8_end"}, 32'(a_wrap), 32'd0);
    chk({tag, "_wrap2_end"}, 32'(b_wrap), (n >= 4) ? 1 : 0);
    x = 0;
    foreach (exp_q[i]) x = x ^ exp_q[i];
`ifdef LOADER_CHECKSUM_EN
    chk({tag, "_csum8"}, 32'(a_csum), x);
    chk({tag, "_csum2"}, 32'(b_csum), x);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bnd_t s2[3];
    int n;

    tbl[0] = '{mk(0, 3, 1, 2, 3, 11'h7FF), 16'h194C};
    tbl[1] = '{mk(1, 4, 7, 0, 5, 11'h01F), 16'h271F};
    tbl[2] = '{mk(2, 10, 5, 6, 2, 11'h0A5), 16'h55A5};
    tbl[3] = '{mk(3, 31, 2, 3, 4, 11'h7FF), 16'hFFFF};
    tbl[4] = '{mk(0, 0, 0, 0, 0, 11'h7FF), 16'h0000};
    tbl[5] = '{mk(0, 31, 7, 7, 7, 11'h000), 16'hFFFC};
    tbl[6] = '{mk(1, 1, 0, 7, 3, 11'h7E0), 16'h08E0};
    tbl[7] = '{mk(2, 2, 3, 7, 7, 11'h700), 16'h1300};
    tbl[8] = '{mk(3, 0, 7, 7, 7, 11'h555), 16'h0555};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(a_ready), 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_done", 32'(a_done), 32'd0);
    chk("rst_we", 32'(a_we), 32'd0);
    chk("rst_addr", 32'(a_addr), 32'd0);
    chk("rst_wdata", 32'(a_wdata), 32'd0);
    chk("rst_wrap", 32'(a_wrap), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_ready", 32'(a_ready), 32'd0);

    // Single R bundle with cycle-exact latency and load_done timing.
    do_start();
    in_valid = 1'b1; in_last = 1'b1;
    drive(tbl[0].bd);
    @(negedge clk);
    chk("s1_ready", 32'(a_ready), 32'd1);
    chk("s1_busy", 32'(a_busy), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    chk("s1_we_early", 32'(a_we), 32'd0);
    @(negedge clk);
    chk("s1_we", 32'(a_we), 32'd1);
    chk("s1_addr", 32'(a_addr), 32'd0);
    chk("s1_wdata", 32'(a_wdata), 32'h194C);
    chk("s1_done_early", 32'(a_done), 32'd0);
    @(negedge clk);
    chk("s1_done", 32'(a_done), 32'd1);
    chk("s1_we_off", 32'(a_we), 32'd0);
    chk("s1_busy_off", 32'(a_busy), 32'd0);
    @(negedge clk);
    chk("s1_done_hold", 32'(a_done), 32'd1);
    #1;

    for (int i = 0; i < 9; i++) begin
      do_start();
      send(tbl[i].bd, 1'b1);
      wait_done();
      chk($sformatf("tbl%0d_n", i), a_data_q.size(), 1);
      if (a_data_q.size() > 0) begin
        chk($sformatf("tbl%0d_word", i), a_data_q[0], tbl[i].word);
        chk($sformatf("tbl%0d_addr", i), a_addr_q[0], 0);
      end
    end

    // Back-to-back I5/I8/I11 stream with randomised unused fields.
    s2[0] = mk(1, 4, 7, 0, $urandom_range(0, 7), 11'h01F | ($urandom_range(0, 63) << 5));
    s2[1] = mk(2, 10, 5, $urandom_range(0, 7), $urandom_range(0, 7), 11'h0A5 | ($urandom_range(0, 7) << 8));
    s2[2] = mk(3, 31, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), 11'h7FF);
    do_start();
    for (int i = 0; i < 3; i++) send(s2[i], i == 2);
    wait_done();
    check_session("s2");
    if (a_data_q.size() == 3) begin
      chk("s2_w0", a_data_q[0], 32'h271F);
      chk("s2_w1", a_data_q[1], 32'h55A5);
      chk("s2_w2", a_data_q[2], 32'hFFFF);
      chk("s2_consec1", a_cyc_q[1], a_cyc_q[0] + 1);
      chk("s2_consec2", a_cyc_q[2], a_cyc_q[0] + 2);
    end
`ifdef LOADER_CHECKSUM_EN
    chk("s2_csum_const", 32'(a_csum), 32'h8D45);
`endif

    // Sustained valid: ten bundles, none lost or duplicated.
    do_start();
    for (int i = 0; i < 10; i++) send(rand_bnd(), i == 9);
    wait_done();
    check_session("stream");

    // Six words with gaps: ADDR_W=2 instance wraps at address 3.
    do_start();
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 2)) idle_cycle();
      send(rand_bnd(), i == 5);
    end
    wait_done();
    check_session("wrap");
    do_start();
    chk("wrap_cleared_by_start", 32'(b_wrap), 32'd0);
    send(rand_bnd(), 1'b1);
    wait_done();
    check_session("after_wrap");

    // Asynchronous reset while draining.
    do_start();
    for (int i = 0; i < 3; i++) send(rand_bnd(), i == 2);
    rst = 1'b1;
    #1;
    chk("mid_rst_we", 32'(a_we), 32'd0);
    chk("mid_rst_addr", 32'(a_addr), 32'd0);
    chk("mid_rst_wdata", 32'(a_wdata), 32'd0);
    chk("mid_rst_busy", 32'(a_busy), 32'd0);
    chk("mid_rst_ready", 32'(a_ready), 32'd0);
    chk("mid_rst_done", 32'(a_done), 32'd0);
    chk("mid_rst_we2", 32'(b_we), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    a_data_q.delete(); b_data_q.delete();
    repeat (5) @(negedge clk);
    #1;
    chk("post_rst_nowrites", a_data_q.size(), 0);
    chk("post_rst_idle_busy", 32'(a_busy), 32'd0);
    chk("post_rst_idle_done", 32'(a_done), 32'd0);
    do_start();
    send(rand_bnd(), 1'b0);
    send(rand_bnd(), 1'b1);
    wait_done();
    check_session("post_rst");

    for (int s = 0; s < 15; s++) begin
      n = $urandom_range(1, 6);
      do_start();
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 2)) idle_cycle();
        send(rand_bnd(), i == n - 1);
      end
      wait_done();
      check_session($sformatf("rand%0d", s));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
